pkt_pad_ctrl: RTL and testbench

//  Padding sequencer for the hash front end. Sits between the message-word source and the compression core.

---
 rtl/pkt_pad_pkg.sv | 20 ++
 rtl/pkt_pad_pktmux.sv | 28 ++
 rtl/pkt_pad_ctrl.sv | 145 ++++++++++++++
 tb/tb_pkt_pad_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/pkt_pad_pkg.sv
// Shared definitions for the padding sequencer.
//   state_t   : sequencer states (message pass-through, pad word, zero fill, length word)
//   PAD_WORD  : pad word for the default 64-bit datapath (MSB set, rest zero)
//   IDX_W     : block index width for the default 16-word block
package pkt_pad_pkg;

  localparam int W_DEF         = 64;
  localparam int BLK_WORDS_DEF = 16;
  localparam int IDX_W         = $clog2(BLK_WORDS_DEF);

  localparam logic [W_DEF-1:0] PAD_WORD = {1'b1, {(W_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_MSG  = 2'd0,
    ST_PAD  = 2'd1,
    ST_ZERO = 2'd2,
    ST_LEN  = 2'd3
  } state_t;

endpackage

// File: rtl/pkt_pad_pktmux.sv
// Output word multiplexer for the padding sequencer.
//   pkt      : message word (pass-through)
//   msg_len  : message length in bits
//   pad_pkt  : select the pad word (highest priority)
//   zero_pkt : select an all-zero word
//   mgln_pkt : select the length word
//   o        : selected word
module pktmux #(
  parameter int w = 64
) (
  input  logic [w-1:0] pkt,
  input  logic [w-1:0] msg_len,
  input  logic         pad_pkt,
  input  logic         zero_pkt,
  input  logic         mgln_pkt,
  output logic [w-1:0] o
);

  localparam logic [w-1:0] PAD_W = {1'b1, {(w-1){1'b0}}};

  always_comb begin
    o = pkt;
    if (pad_pkt)       o = PAD_W;
    else if (zero_pkt) o = '0;
    else if (mgln_pkt) o = msg_len;
  end

endmodule

// File: rtl/pkt_pad_ctrl.sv
// Padding sequencer for the hash front end.
// Passes message words straight through, then appends a pad word, zero
// words up to block index BLK_WORDS-2 and a final bit-length word so that
// every message ends on a whole block.
//   clk, rst             : clock, asynchronous active-high reset
//   in_data/valid/last   : message word stream from the source
//   in_ready             : word accepted this cycle
//   out_data/valid/ready : word stream to the compression core
//   blk_end              : out_data is block index BLK_WORDS-1
//   msg_end              : out_data is the length word
//
// state   | meaning
// ST_MSG  | message words pass through combinationally
// ST_PAD  | emitting the pad word
// ST_ZERO | emitting zero fill up to index BLK_WORDS-2
// ST_LEN  | emitting the bit-length word
module pkt_pad_ctrl
  import pkt_pad_pkg::*;
#(
  parameter int W         = 64,
  parameter int BLK_WORDS = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         in_last,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         blk_end,
  output logic         msg_end
);

  localparam int            LIDX_W     = $clog2(BLK_WORDS);
  localparam logic [LIDX_W-1:0] IDX_LAST   = LIDX_W'(BLK_WORDS - 1);
  localparam logic [LIDX_W-1:0] IDX_PENULT = LIDX_W'(BLK_WORDS - 2);
  localparam logic [LIDX_W-1:0] IDX_ONE    = LIDX_W'(1);
  localparam logic [W-1:0]      LEN_STEP   = W'(W);

  state_t            r_state;
  logic [LIDX_W-1:0] r_idx;
  logic [W-1:0]      r_len;

  state_t            w_state_nxt;
  logic [LIDX_W-1:0] w_idx_nxt;
  logic [W-1:0]      w_len_nxt;
  logic              w_pad_pkt;
  logic              w_zero_pkt;
  logic              w_mgln_pkt;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_msg_end;
  logic              w_out_xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_MSG;
      r_idx   <= '0;
      r_len   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_len   <= w_len_nxt;
    end
  end

  // In MSG the handshakes are gated by rst so nothing is offered or
  // accepted while reset is held, even though the state already reads MSG.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_len_nxt   = r_len;
    w_pad_pkt   = 1'b0;
    w_zero_pkt  = 1'b0;
    w_mgln_pkt  = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_msg_end   = 1'b0;
    w_out_xfer  = 1'b0;
    case (r_state)
      ST_MSG: begin
        w_out_valid = in_valid & ~rst;
        w_in_ready  = out_ready & ~rst;
        w_out_xfer  = in_valid & w_in_ready;
        if (w_out_xfer) begin
          w_idx_nxt = r_idx + IDX_ONE;
          w_len_nxt = r_len + LEN_STEP;
          if (in_last) w_state_nxt = ST_PAD;
        end
      end
      ST_PAD: begin
        w_pad_pkt   = 1'b1;
        w_out_valid = 1'b1;
        w_out_xfer  = out_ready;
        // Index BLK_WORDS-2 must always hold a zero word, so the pad word
        // is always followed by at least one zero; a pad at the last two
        // indices rolls the fill into a further block.
        if (w_out_xfer) begin
          w_idx_nxt   = r_idx + IDX_ONE;
          w_state_nxt = ST_ZERO;
        end
      end
      ST_ZERO: begin
        w_zero_pkt  = 1'b1;
        w_out_valid = 1'b1;
        w_out_xfer  = out_ready;
        if (w_out_xfer) begin
          w_idx_nxt = r_idx + IDX_ONE;
          if (r_idx == IDX_PENULT) w_state_nxt = ST_LEN;
        end
      end
      ST_LEN: begin
        w_mgln_pkt  = 1'b1;
        w_out_valid = 1'b1;
        w_msg_end   = 1'b1;
        w_out_xfer  = out_ready;
        if (w_out_xfer) begin
          w_idx_nxt   = '0;
          w_len_nxt   = '0;
          w_state_nxt = ST_MSG;
        end
      end
      default: begin
        w_state_nxt = ST_MSG;
      end
    endcase
  end

  pktmux #(.w(W)) u_pktmux (
    .pkt      (in_data),
    .msg_len  (r_len),
    .pad_pkt  (w_pad_pkt),
    .zero_pkt (w_zero_pkt),
    .mgln_pkt (w_mgln_pkt),
    .o        (out_data)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign msg_end   = w_msg_end;
  assign blk_end   = w_out_valid & (r_idx == IDX_LAST);

endmodule

// File: tb/tb_pkt_pad_ctrl.sv
module tb_pkt_pad_ctrl;

  localparam int W   = 64;
  localparam int BLK = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic         out_ready;
  logic         blk_end;
  logic         msg_end;

  int n_cmp = 0;
  int n_bad = 0;

  logic [W-1:0] msg_q[$];

  pkt_pad_ctrl #(.W(W), .BLK_WORDS(BLK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .blk_end   (blk_end),
    .msg_end   (msg_end)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Total padded length: message + pad + at least one zero + length word,
  // rounded up to whole blocks.
  function automatic int total_words(input int n);
    return ((n + 3 + BLK - 1) / BLK) * BLK;
  endfunction

  function automatic logic [W-1:0] exp_word(input int p, input int n);
    if (p < n) return msg_q[p];
    if (p == n) return {1'b1, {(W-1){1'b0}}};
    if (p == total_words(n) - 1) return W'(n) * W'(W);
    return '0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  W'(in_ready),  '0);
    chk({tag, "_out_valid"}, W'(out_valid), '0);
    chk({tag, "_blk_end"},   W'(blk_end),   '0);
    chk({tag, "_msg_end"},   W'(msg_end),   '0);
    chk({tag, "_passthru"},  out_data,      in_data);
  endtask

  // mode 0: valid/ready always 1; 1: ready alternates 1,0; 2: random both.
  // abort_at >= 0 pulses reset once the output position reaches it.
  task automatic run_msg(input int n, input int mode, input int abort_at);
    int  p     = 0;
    int  total = total_words(n);
    int  cyc   = 0;
    bit  held  = 1'b0;
    bit  done  = 1'b0;
    bit  vld, rdy, exp_ov;
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back({$urandom, $urandom});
    while (!done) begin
      @(negedge clk);
      if (abort_at >= 0 && p == abort_at) begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = {$urandom, $urandom};
        #1;
        check_reset_outputs("midrst");
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2) == 0;
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      if (p < n) begin
        vld     = (mode == 2) ? (held | ($urandom_range(0, 3) != 0)) : 1'b1;
        in_data = msg_q[p];
        in_last = (p == n - 1);
      end else begin
        vld     = $urandom_range(0, 1) != 0;
        in_data = {$urandom, $urandom};
        in_last = $urandom_range(0, 1) != 0;
      end
      in_valid  = vld;
      out_ready = rdy;
      #1;
      exp_ov = (p < n) ? vld : 1'b1;
      chk($sformatf("out_valid[%0d]", p), W'(out_valid), W'(exp_ov));
      chk($sformatf("in_ready[%0d]", p),  W'(in_ready),  W'((p < n) && rdy));
      if (exp_ov) begin
        chk($sformatf("out_data[%0d]", p), out_data, exp_word(p, n));
        chk($sformatf("blk_end[%0d]", p),  W'(blk_end), W'((p % BLK) == BLK - 1));
        chk($sformatf("msg_end[%0d]", p),  W'(msg_end), W'(p == total - 1));
      end
      held = (p < n) && vld && !rdy;
      if (exp_ov && rdy) begin
        if (p == total - 1) done = 1'b1;
        p++;
      end
      cyc++;
      if (!done && cyc > 2000) begin
        chk("timeout", W'(p), W'(total));
        done = 1'b1;
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = 64'h0123_4567_89AB_CDEF;
    in_valid  = 1'b1;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;

    run_msg(1, 0, -1);
    run_msg(13, 0, -1);
    run_msg(14, 0, -1);
    run_msg(16, 0, -1);
    run_msg(1, 0, -1);
    run_msg(3, 1, -1);
    run_msg(5, 0, 8);
    run_msg(2, 0, -1);
    for (int k = 0; k < 12; k++) run_msg($urandom_range(1, 40), 2, -1);
    run_msg(7, 2, 20);
    run_msg(15, 2, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
